// File: rtl/switch_debounce_repeat.sv
// Purpose : synchronise and debounce one raw push-button, emit press/release/auto-repeat events.
// Latency : o_Switch follows a stable input DEBOUNCE_TIME+2 edges after first sample; events registered.
// Backpressure: none; free-running conditioning stage, events are single-cycle pulses.
//
// Ports:
//   i_Clk      system clock
//   i_Rst      synchronous reset, active-high, highest priority
//   i_Switch   raw asynchronous switch level, 1 = pressed
//   o_Switch   debounced switch level
//   o_Press    one-cycle pulse in the first cycle o_Switch is 1
//   o_Release  one-cycle pulse in the first cycle o_Switch is 0 after being 1
//   o_Repeat   one-cycle auto-repeat pulse while the switch is held
//   o_Held     high while the hold FSM is in the repeating state
module switch_debounce_repeat #(
    parameter int DEBOUNCE_TIME = 250_000,
    parameter int HOLD_TIME     = 12_500_000,
    parameter int REPEAT_TIME   = 2_500_000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Repeat,
    output logic o_Held
);

    localparam int DW = $clog2(DEBOUNCE_TIME + 1);
    localparam int HW = $clog2(HOLD_TIME + 1);
    localparam int RW = $clog2(REPEAT_TIME + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TIME - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIME - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_TIME - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESSED   = 2'd1;
    localparam logic [1:0] ST_REPEATING = 2'd2;

    logic          sync_s1;
    logic          sync_s2;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rpt_cnt;
    logic [1:0]    state;

    logic db_flip;
    logic db_rise;
    logic db_fall;
    logic hold_done;
    logic rpt_done;

    // The debounced level flips on this edge; the FSM and the edge pulses
    // act on it in the same edge so release can pre-empt a due repeat.
    assign db_flip   = (sync_s2 != o_Switch) && (db_cnt == DB_LAST);
    assign db_rise   = db_flip && !o_Switch;
    assign db_fall   = db_flip && o_Switch;
    assign hold_done = (hold_cnt == HOLD_LAST);
    assign rpt_done  = (rpt_cnt == RPT_LAST);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync_s1   <= 1'b0;
            sync_s2   <= 1'b0;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            rpt_cnt   <= '0;
            state     <= ST_IDLE;
            o_Switch  <= 1'b0;
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
            o_Repeat  <= 1'b0;
            o_Held    <= 1'b0;
        end else begin
            sync_s1 <= i_Switch;
            sync_s2 <= sync_s1;

            // Any sample agreeing with the current level restarts the count,
            // so only an unbroken run of DEBOUNCE_TIME disagreements flips it.
            if (sync_s2 != o_Switch) begin
                if (db_flip) begin
                    o_Switch <= sync_s2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end

            o_Press   <= db_rise;
            o_Release <= db_fall;
            o_Repeat  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    hold_cnt <= '0;
                    o_Held   <= 1'b0;
                    if (db_rise) begin
                        state <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (db_fall) begin
                        state  <= ST_IDLE;
                        o_Held <= 1'b0;
                    end else if (hold_done) begin
                        state    <= ST_REPEATING;
                        o_Repeat <= 1'b1;
                        o_Held   <= 1'b1;
                        rpt_cnt  <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                        o_Held   <= 1'b0;
                    end
                end
                ST_REPEATING: begin
                    if (db_fall) begin
                        state  <= ST_IDLE;
                        o_Held <= 1'b0;
                    end else begin
                        o_Held <= 1'b1;
                        if (rpt_done) begin
                            o_Repeat <= 1'b1;
                            rpt_cnt  <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + RW'(1);
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_Held <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debounce_repeat.sv
// Purpose : exercise switch_debounce_repeat against a window-based behavioural model and fixed timings.
// Latency : model predicts the outputs visible in the cycle after each rising edge.
// Backpressure: not applicable; stimulus is driven on falling edges.
module tb_switch_debounce_repeat;

    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int RPT  = 8;

    logic clk;
    logic rst;
    logic sw;
    logic o_sw, o_press, o_release, o_repeat, o_held;

    int total = 0;
    int bad   = 0;
    int rep_seen = 0;

    switch_debounce_repeat #(
        .DEBOUNCE_TIME (DB),
        .HOLD_TIME     (HOLD),
        .REPEAT_TIME   (RPT)
    ) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_Switch  (sw),
        .o_Switch  (o_sw),
        .o_Press   (o_press),
        .o_Release (o_release),
        .o_Repeat  (o_repeat),
        .o_Held    (o_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The debounced level flips when the last DB synchroniser samples since
    // reset all disagree with it; the synchroniser sample seen at edge k is
    // the input sampled at edge k-2.  Repeat/held follow from the age of the
    // current press.
    logic inp_q[$];
    logic s2_q[$];
    int   k;
    logic lvl;
    bit   pressed;
    int   press_c;
    int   age;
    logic s2v;
    bit   flip;
    bit   mvalid = 0;
    logic e_sw = 0, e_press = 0, e_release = 0, e_repeat = 0, e_held = 0;

    always @(posedge clk) begin
        if (rst) begin
            k = 0; lvl = 1'b0; pressed = 0; press_c = 0;
            inp_q.delete(); s2_q.delete();
            e_sw = 0; e_press = 0; e_release = 0; e_repeat = 0; e_held = 0;
            mvalid = 1;
        end else if (mvalid) begin
            inp_q.push_back(sw);
            s2v = (k >= 2) ? inp_q[k-2] : 1'b0;
            s2_q.push_back(s2v);
            flip = (k >= DB - 1);
            for (int j = k - DB + 1; j <= k; j++) begin
                if (j < 0 || s2_q[j] == lvl) flip = 0;
            end
            e_press   = flip && !lvl;
            e_release = flip && lvl;
            if (flip) lvl = ~lvl;
            k++;
            if (e_press) begin
                pressed = 1;
                press_c = k;
            end
            if (e_release) pressed = 0;
            age = k - press_c;
            e_sw     = lvl;
            e_held   = pressed && (age >= HOLD);
            e_repeat = pressed && (age >= HOLD) && (((age - HOLD) % RPT) == 0);
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_switch",  o_sw,      e_sw);
            chk("model_press",   o_press,   e_press);
            chk("model_release", o_release, e_release);
            chk("model_repeat",  o_repeat,  e_repeat);
            chk("model_held",    o_held,    e_held);
            if (o_repeat) rep_seen++;
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_press(input int lat);
        for (int m = 1; m <= lat; m++) begin
            @(negedge clk);
            if (m < lat) begin
                chk("press_early_sw", o_sw, 1'b0);
                chk("press_early", o_press, 1'b0);
            end else begin
                chk("press_at_lat", o_press, 1'b1);
                chk("press_sw_high", o_sw, 1'b1);
            end
        end
    endtask

    task automatic expect_release(input int lat);
        for (int m = 1; m <= lat; m++) begin
            @(negedge clk);
            if (m < lat) begin
                chk("release_early", o_release, 1'b0);
            end else begin
                chk("release_at_lat", o_release, 1'b1);
                chk("release_sw_low", o_sw, 1'b0);
            end
        end
    endtask

    // Entered in the press cycle P; d counts cycles after P.  The switch is
    // dropped at d == drop_at, so the release lands at drop_at + DB + 2.
    task automatic hold_phase(input int drop_at, input int end_at);
        int  rel_d;
        bit  active;
        rel_d = drop_at + DB + 2;
        for (int d = 1; d <= end_at; d++) begin
            @(negedge clk);
            active = (d < rel_d);
            chk("hold_press",   o_press,   1'b0);
            chk("hold_release", o_release, (d == rel_d));
            chk("hold_held",    o_held,    active && d >= HOLD);
            chk("hold_repeat",  o_repeat,  active && d >= HOLD && ((d - HOLD) % RPT) == 0);
            if (d == drop_at) sw = 1'b0;
        end
    endtask

    int rep_before;

    initial begin
        rst = 1'b1;
        sw  = 1'b1;
        // Reset with the switch held: everything low, then a fresh press.
        repeat (3) begin
            @(negedge clk);
            chk("rst_sw", o_sw, 1'b0);
            chk("rst_press", o_press, 1'b0);
            chk("rst_held", o_held, 1'b0);
            chk("rst_repeat", o_repeat, 1'b0);
        end
        rst = 1'b0;
        expect_press(6);
        @(negedge clk);
        chk("press_single", o_press, 1'b0);
        sw = 1'b0;
        expect_release(6);
        @(negedge clk);
        chk("release_single", o_release, 1'b0);
        step(10);

        // Clean press held 10 cycles, then release; no repeat.
        rep_before = rep_seen;
        sw = 1'b1;
        expect_press(6);
        step(4);
        sw = 1'b0;
        expect_release(6);
        step(10);
        chk("clean_no_repeat", (rep_seen != rep_before), 1'b0);

        // Bounce 1,0,1,1,0,1 then steady 1: single press 11 cycles after start.
        sw = 1'b1; @(negedge clk); chk("bounce_sw0", o_sw, 1'b0);
        sw = 1'b0; @(negedge clk); chk("bounce_sw1", o_sw, 1'b0);
        sw = 1'b1; @(negedge clk); chk("bounce_sw2", o_sw, 1'b0);
        sw = 1'b1; @(negedge clk); chk("bounce_sw3", o_sw, 1'b0);
        sw = 1'b0; @(negedge clk); chk("bounce_sw4", o_sw, 1'b0);
        sw = 1'b1; @(negedge clk); chk("bounce_sw5", o_sw, 1'b0);
        expect_press(5);

        // Auto-repeat at P+20,28,...,60; drop at P+60, release at P+66.
        hold_phase(60, 68);
        step(10);

        // Release lands exactly where the second repeat would fire.
        sw = 1'b1;
        expect_press(6);
        hold_phase(22, 32);
        step(10);

        // Reset while repeating.
        sw = 1'b1;
        expect_press(6);
        hold_phase(1000, 30);
        rst = 1'b1;
        sw  = 1'b0;
        @(negedge clk);
        chk("midrst_held", o_held, 1'b0);
        chk("midrst_sw", o_sw, 1'b0);
        chk("midrst_repeat", o_repeat, 1'b0);
        chk("midrst_release", o_release, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("postrst_no_release", o_release, 1'b0);
        end
        sw = 1'b1;
        expect_press(6);
        sw = 1'b0;
        expect_release(6);
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1);
    end

endmodule
